// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: releases N_CH reset domains in thermometer order after a
// synchronous or soft restart. Optional watchdog restart is enabled by defining RST_SEQ_GEN_WDT_EN.
module rst_seq_gen #(
    parameter int N_CH     = 4,
    parameter int HOLD_CYC = 2,
    parameter int STEP_CYC = 4,
    parameter int CNT_W    = 16,
    parameter int WDT_CYC  = 64
) (
    input  logic             i_clk,
    input  logic             i_sync_rst,
    input  logic             i_soft_rst_req,
    input  logic             i_wdt_kick,
    output logic [N_CH-1:0]  o_rst,
    output logic             o_busy,
    output logic             o_seq_done,
    output logic [CNT_W-1:0] o_cyc_cnt,
    output logic [7:0]       o_soft_cnt,
    output logic             o_wdt_fire
);

    localparam int T_MAX = HOLD_CYC + (N_CH - 1) * STEP_CYC;
    localparam int TMR_W = $clog2(T_MAX + 1);

    if (N_CH < 1 || HOLD_CYC < 1 || STEP_CYC < 1 || WDT_CYC < 1) begin : g_param_check
        $error("rst_seq_gen: N_CH, HOLD_CYC, STEP_CYC and WDT_CYC must all be >= 1");
    end

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [TMR_W-1:0]  tmr_q;
    logic [TMR_W-1:0]  tmr_d;
    logic [N_CH-1:0]   rst_d;
    logic [CNT_W-1:0]  cyc_d;
    logic [7:0]        soft_d;
    logic              soft_prev_q;
    logic              soft_rise;
    logic              rs;
    logic              restart;
    logic              wdt_trip;

    assign rs        = i_sync_rst | i_soft_rst_req;
    assign restart   = rs | wdt_trip;
    assign soft_rise = i_soft_rst_req & ~soft_prev_q;

`ifdef RST_SEQ_GEN_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYC + 1);

    logic [WDT_W-1:0] wdt_q;
    logic [WDT_W-1:0] wdt_d;

    // The counter only runs in DONE; reaching WDT_CYC acts like a soft restart on that edge.
    always_comb begin
        wdt_d    = '0;
        wdt_trip = 1'b0;
        if (!rs && state_q == ST_DONE && !i_wdt_kick) begin
            if (wdt_q + WDT_W'(1) == WDT_W'(WDT_CYC)) begin
                wdt_trip = 1'b1;
            end else begin
                wdt_d = wdt_q + WDT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            wdt_q      <= '0;
            o_wdt_fire <= 1'b0;
        end else begin
            wdt_q      <= wdt_d;
            o_wdt_fire <= wdt_trip;
        end
    end
`else
    logic unused_wdt_kick;

    assign unused_wdt_kick = i_wdt_kick;
    assign wdt_trip        = 1'b0;
    assign o_wdt_fire      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rst_d   = o_rst;
        cyc_d   = o_cyc_cnt;
        soft_d  = o_soft_cnt;

        if (restart) begin
            state_d = ST_ASSERT;
            tmr_d   = '0;
            rst_d   = '1;
            cyc_d   = '0;
        end else if (state_q == ST_DONE) begin
            if (o_cyc_cnt != '1) begin
                cyc_d = o_cyc_cnt + CNT_W'(1);
            end
        end else begin
            // Channel k drops once the timer reaches its offset; offsets grow with k,
            // so the vector stays thermometer-shaped and released bits never re-assert.
            tmr_d = tmr_q + TMR_W'(1);
            for (int k = 0; k < N_CH; k++) begin
                rst_d[k] = (int'(tmr_d) < HOLD_CYC + k * STEP_CYC);
            end
            if (rst_d == '0) begin
                state_d = ST_DONE;
            end else if (!rst_d[0]) begin
                state_d = ST_RELEASE;
            end else begin
                state_d = ST_HOLD;
            end
        end

        if (i_sync_rst) begin
            soft_d = '0;
        end else if ((soft_rise || wdt_trip) && o_soft_cnt != 8'hFF) begin
            soft_d = o_soft_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            state_q     <= ST_ASSERT;
            tmr_q       <= '0;
            o_rst       <= '1;
            o_busy      <= 1'b1;
            o_seq_done  <= 1'b0;
            o_cyc_cnt   <= '0;
            o_soft_cnt  <= '0;
            soft_prev_q <= i_soft_rst_req;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            o_rst       <= rst_d;
            o_busy      <= (state_d != ST_DONE);
            o_seq_done  <= (state_d == ST_DONE);
            o_cyc_cnt   <= cyc_d;
            o_soft_cnt  <= soft_d;
            soft_prev_q <= i_soft_rst_req;
        end
    end

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
- Synthesisable, parametrised multi-channel reset sequencer. It generalises the two-cycle reset drive used in our benches.
- Takes the single synchronous top-level reset and releases N_CH downstream reset domains in order, at programmable cycle offsets.
- Supports soft re-triggering, reports sequence completion, and counts cycles since completion.
- Sits directly under top, feeding the per-subsystem reset inputs.

Parameters:
- N_CH, 4, number of reset output channels; must be >= 1.
- HOLD_CYC, 2, cycles from reset release to o_rst[0] deassert; must be >= 1.
- STEP_CYC, 4, cycles between successive channel releases; must be >= 1.
- CNT_W, 16, width of o_cyc_cnt.
- WDT_CYC, 64, watchdog timeout in cycles; used only with RST_SEQ_GEN_WDT_EN; must be >= 1.

Ports:
- i_clk  in  1  clock.
- i_sync_rst  in  1  synchronous active-high reset.
- i_soft_rst_req  in  1  soft restart request, level-sensitive.
- i_wdt_kick  in  1  watchdog kick (optional feature).
- o_rst  out  N_CH  per-channel active-high reset, registered.
- o_busy  out  1  high while the sequence is not complete.
- o_seq_done  out  1  high once all channels are released.
- o_cyc_cnt  out  CNT_W  cycles spent in DONE, saturating.
- o_soft_cnt  out  8  number of soft restarts, saturating at 255.
- o_wdt_fire  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Clock is i_clk only. Reset i_sync_rst is synchronous, active-high. All outputs are registered.
- Elaboration error (generate-time $error) if N_CH, HOLD_CYC, STEP_CYC or WDT_CYC < 1.
- Reset values while i_sync_rst = 1:
  - o_rst = all ones, o_busy = 1, o_seq_done = 0.
  - o_cyc_cnt = 0, o_soft_cnt = 0, o_wdt_fire = 0.
- Effective restart: rs = i_sync_rst | i_soft_rst_req. While rs = 1:
  - o_rst = all ones, o_busy = 1, o_seq_done = 0, o_cyc_cnt = 0.
  - Internal timer = 0.
- Time origin: edge E0 is the first rising edge at which rs is sampled 0.
- FSM states:
  - ASSERT: rs = 1.
  - HOLD: before o_rst[0] is released.
  - RELEASE: between channel releases.
  - DONE: all channels released.
- Transitions:
  - rs = 1 from any state -> ASSERT.
  - ASSERT -> HOLD at E0.
  - HOLD -> RELEASE when o_rst[0] falls.
  - RELEASE -> DONE when o_rst[N_CH-1] falls.
  - If N_CH = 1: HOLD -> DONE directly.
- Release timing:
  - o_rst[k] is 0 after edge E0 + HOLD_CYC - 1 + k*STEP_CYC.
  - I.e. o_rst[k] is first seen low HOLD_CYC + k*STEP_CYC cycles after rs was last high.
  - Once low, a bit stays low until the next restart.
  - At every point, o_rst is thermometer-shaped: bit k low implies all bits j < k are low.
- Completion: o_seq_done rises on the same edge that o_rst[N_CH-1] falls. o_busy = ~o_seq_done at all times.
- o_cyc_cnt: increments by 1 on each edge in DONE. Saturates at 2^CNT_W - 1, no wrap.
- o_soft_cnt:
  - Increments on each rising edge of i_soft_rst_req (0->1 as sampled) while i_sync_rst = 0.
  - Saturates at 255.
  - Cleared only by i_sync_rst.
- Holding i_soft_rst_req high holds the sequence in ASSERT but counts as a single restart.
- A restart in any state (HOLD, RELEASE or DONE) re-asserts all o_rst on the next edge. The sequence timing restarts from the new E0.
- i_sync_rst and i_soft_rst_req high together: i_sync_rst dominates, and o_soft_cnt is cleared, not incremented.
- Internal timer width = $clog2(HOLD_CYC + (N_CH-1)*STEP_CYC + 1). The timer stops in DONE.

Optional Feature:
- Macro: RST_SEQ_GEN_WDT_EN.
- Defined:
  - In DONE, a watchdog counter increments each cycle and clears on any cycle with i_wdt_kick = 1.
  - When the counter reaches WDT_CYC, o_wdt_fire pulses high for exactly 1 cycle.
  - The block then behaves as a soft restart: all o_rst re-assert on that same edge and o_soft_cnt increments.
  - The watchdog counter is held at 0 outside DONE.
- Not defined: i_wdt_kick is ignored, o_wdt_fire is tied to 0, and no watchdog logic is synthesised.

Test Plan (defaults unless stated):
- Sequence timing: i_sync_rst high 3 cycles then low.
  - o_rst[0..3] fall 2, 6, 10, 14 cycles after release.
  - o_seq_done rises with o_rst[3]. o_cyc_cnt = 5 five cycles later.
- Mid-sequence restart: pulse i_soft_rst_req for 1 cycle, 8 cycles after release.
  - o_rst returns to 4'b1111 on the next edge; new releases at +2/+6/+10/+14 from the pulse end.
  - o_soft_cnt = 1.
- Saturation: CNT_W = 4, remain in DONE for 20 cycles -> o_cyc_cnt holds at 15. Then 300 soft pulses -> o_soft_cnt = 255.
- Simultaneous resets: i_sync_rst and i_soft_rst_req high on the same edge -> o_soft_cnt = 0 and o_rst = all ones. Sequence timing counts from i_sync_rst release.
- Edge parameters: N_CH = 1, HOLD_CYC = 1 -> o_rst[0] and o_seq_done change 1 cycle after release. Then N_CH = 8, STEP_CYC = 1 -> consecutive-cycle thermometer release.
- Watchdog (RST_SEQ_GEN_WDT_EN, WDT_CYC = 10):
  - Kick every 5 cycles -> no fire.
  - Stop kicking -> o_wdt_fire 1-cycle pulse 10 cycles after the last kick, all o_rst re-assert, o_soft_cnt increments.
  - Without the macro, no fire ever.
